// File: rtl/spi_master_tx_multi.sv
// spi_master_tx_multi: multi-line (1/2/4) SPI TX shifter that stalls the SPI clock instead of ending a transfer when the FIFO runs dry.
module spi_master_tx_multi #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             abort,
  input  logic             tx_edge,
  input  logic [1:0]       mode,
  input  logic             lsb_first,
  input  logic [CNT_W-1:0] bit_len,
  input  logic             bit_len_upd,
  input  logic [DW-1:0]    data,
  input  logic             data_valid,
  output logic             data_ready,
  output logic [3:0]       sdo,
  output logic             clk_en_o,
  output logic             tx_done,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, TRANSMIT, STALL} state_t;
  state_t state, state_n;
  logic [DW-1:0]    shreg, shreg_n, shifted;
  logic [CNT_W-1:0] beat, beat_n, wbeat, wbeat_n, target, target_n;
  logic [1:0]       mode_r, mode_n, s_r;
  logic             lsb_r, lsb_n, last, wlast;
  logic [2:0]       l_r;
  function automatic logic [1:0] shamt(input logic [1:0] m);
    return m == 2'b01 ? 2'd1 : m == 2'b10 ? 2'd2 : 2'd0;
  endfunction
  assign s_r     = shamt(mode_r);
  assign l_r     = 3'd1 << s_r;
  assign shifted = lsb_r ? shreg >> l_r : shreg << l_r;
  assign last    = beat == target - CNT_W'(1);
  assign wlast   = wbeat == (CNT_W'(DW) >> s_r) - CNT_W'(1);
  assign busy    = state != IDLE;
  assign sdo = lsb_r ? (s_r == 2'd2 ? shreg[3:0] : s_r == 2'd1 ? {2'b0, shreg[1:0]} : {3'b0, shreg[0]})
                     : (s_r == 2'd2 ? shreg[DW-1:DW-4] : s_r == 2'd1 ? {2'b0, shreg[DW-1:DW-2]} : {3'b0, shreg[DW-1]});
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state  <= IDLE;
      shreg  <= '0;
      beat   <= '0;
      wbeat  <= '0;
      target <= CNT_W'(8);
      mode_r <= '0;
      lsb_r  <= 1'b0;
    end else begin
      state  <= state_n;
      shreg  <= shreg_n;
      beat   <= beat_n;
      wbeat  <= wbeat_n;
      target <= target_n;
      mode_r <= mode_n;
      lsb_r  <= lsb_n;
    end
  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    beat_n     = beat;
    wbeat_n    = wbeat;
    target_n   = target;
    mode_n     = mode_r;
    lsb_n      = lsb_r;
    data_ready = 1'b0;
    clk_en_o   = 1'b0;
    tx_done    = 1'b0;
    if (abort) begin
      state_n = IDLE;
      shreg_n = '0;
      beat_n  = '0;
      wbeat_n = '0;
    end else
      case (state)
        IDLE: begin
          if (bit_len_upd) target_n = bit_len >> shamt(mode);
          if (en && data_valid && target != '0) begin
            shreg_n    = data;
            data_ready = 1'b1;
            beat_n     = '0;
            wbeat_n    = '0;
            mode_n     = mode;
            lsb_n      = lsb_first;
            state_n    = TRANSMIT;
          end
        end
        TRANSMIT: begin
          clk_en_o = 1'b1;
          if (tx_edge) begin
            shreg_n = shifted;
            beat_n  = beat + CNT_W'(1);
            wbeat_n = wbeat + CNT_W'(1);
            // last beat outranks the word boundary when both land on one edge
            if (last) begin
              tx_done = 1'b1;
              beat_n  = '0;
              wbeat_n = '0;
              if (en && data_valid) begin
                shreg_n    = data;
                data_ready = 1'b1;
              end else begin
                clk_en_o = 1'b0;
                state_n  = IDLE;
              end
            end else if (wlast) begin
              wbeat_n = '0;
              if (data_valid) begin
                shreg_n    = data;
                data_ready = 1'b1;
              end else begin
                clk_en_o = 1'b0;
                state_n  = STALL;
              end
            end
          end
        end
        STALL: begin
          if (data_valid) begin
            shreg_n    = data;
            data_ready = 1'b1;
            clk_en_o   = 1'b1;
            state_n    = TRANSMIT;
          end
        end
        default: state_n = IDLE;
      endcase
  end
endmodule

// File: tb/tb_spi_master_tx_multi.sv
// tb_spi_master_tx_multi: scoreboard bench; expected sdo beats are derived from word/bit arithmetic and checked by an independent monitor.
module tb_spi_master_tx_multi;
  localparam int DW = 32, CNT_W = 16;
  logic clk = 0, rstn = 0, en = 0, abort = 0, tx_edge = 0, lsb_first = 0, bit_len_upd = 0, data_valid = 0;
  logic [1:0] mode = 0;
  logic [CNT_W-1:0] bit_len = 0;
  logic [DW-1:0] data = 0;
  logic data_ready, clk_en_o, tx_done, busy;
  logic [3:0] sdo;
  typedef struct {logic [3:0] sdo; logic last;} beat_t;
  beat_t exp_q[$];
  logic [DW-1:0] words[$];
  int n_tests = 0, n_fail = 0, n_done = 0, n_edges = 0;
  bit gen_on = 0;
  logic prev_en = 0;

  spi_master_tx_multi #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .en(en), .abort(abort), .tx_edge(tx_edge), .mode(mode),
    .lsb_first(lsb_first), .bit_len(bit_len), .bit_len_upd(bit_len_upd), .data(data),
    .data_valid(data_valid), .data_ready(data_ready), .sdo(sdo), .clk_en_o(clk_en_o),
    .tx_done(tx_done), .busy(busy));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Clock generator model: strobes only while the enable was seen high on the previous cycle.
  initial forever begin
    @(negedge clk);
    prev_en = clk_en_o;
    @(posedge clk);
    #1 tx_edge = gen_on && prev_en && ($urandom_range(0, 3) != 0);
  end

  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (tx_edge && busy) begin
        n_edges++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL extra_beat: got sdo %0h, expected no beat", sdo);
        end else begin
          e = exp_q.pop_front();
          chk("sdo", {60'd0, sdo}, {60'd0, e.sdo});
          chk("tx_done", {63'd0, tx_done}, {63'd0, e.last});
        end
      end else if (tx_done) begin
        n_tests++;
        n_fail++;
        $display("FAIL spurious_tx_done: got 1, expected 0");
      end
      if (tx_done) n_done++;
    end
  end

  function automatic int lines(input logic [1:0] m);
    return m == 2'd1 ? 2 : m == 2'd2 ? 4 : 1;
  endfunction

  task automatic push_exp(input logic [1:0] m, input logic lsb, input int t);
    int l, wpw;
    logic [DW-1:0] w, v;
    beat_t e;
    l = lines(m);
    wpw = DW / l;
    for (int k = 0; k < t; k++) begin
      w = words[k / wpw];
      v = lsb ? w >> (l * (k % wpw)) : w >> (DW - l * (k % wpw + 1));
      e.sdo = v[3:0] & 4'((1 << l) - 1);
      e.last = (k == t - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept;
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!data_ready && t < 1000);
    if (!data_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got data_ready 0, expected 1");
    end
  endtask

  task automatic feed(input int gap, input bit mid_upd);
    int d0, t;
    d0 = n_done;
    en = 1;
    for (int i = 0; i < words.size(); i++) begin
      if (i > 0 && gap > 0) begin
        data_valid = 0;
        t = 0;
        do begin
          @(negedge clk);
          t++;
        end while (!(busy && !clk_en_o) && t < 1000);
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          chk("stall_clk_en", {63'd0, clk_en_o}, 64'd0);
          chk("stall_busy", {63'd0, busy}, 64'd1);
        end
        step;
      end
      data = words[i];
      data_valid = 1;
      wait_accept;
      step;
    end
    data_valid = 0;
    if (mid_upd) begin
      bit_len_upd = 1;
      bit_len = CNT_W'(8);
      step;
      bit_len_upd = 0;
    end
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (busy && t < 3000);
    chk("idle_after_xfer", {63'd0, busy}, 64'd0);
    chk("clk_en_idle", {63'd0, clk_en_o}, 64'd0);
    chk("beats_left", 64'(exp_q.size()), 64'd0);
    chk("tx_done_count", 64'(n_done - d0), 64'd1);
    step;
  endtask

  task automatic run_xfer(input logic [1:0] m, input logic lsb, input int blen, input int gap, input bit mid_upd);
    int t;
    mode = m;
    lsb_first = lsb;
    bit_len = CNT_W'(blen);
    bit_len_upd = 1;
    step;
    bit_len_upd = 0;
    t = blen >> (lines(m) == 4 ? 2 : lines(m) == 2 ? 1 : 0);
    push_exp(m, lsb, t);
    feed(gap, mid_upd);
  endtask

  task automatic start_single32;
    int t;
    words = '{$urandom()};
    mode = 0;
    lsb_first = 0;
    bit_len = CNT_W'(32);
    bit_len_upd = 1;
    step;
    bit_len_upd = 0;
    push_exp(2'd0, 1'b0, 32);
    en = 1;
    data = words[0];
    data_valid = 1;
    wait_accept;
    step;
    data_valid = 0;
  endtask

  task automatic wait_edges(input int n);
    int e0, t;
    e0 = n_edges;
    t = 0;
    do begin
      @(negedge clk);
      #1;
      t++;
    end while (n_edges < e0 + n && t < 1000);
    if (n_edges < e0 + n) begin
      n_tests++;
      n_fail++;
      $display("FAIL edge_timeout: got %0d edges, expected %0d", n_edges - e0, n);
    end
  endtask

  initial begin
    int m, l, t, nw;
    repeat (3) @(negedge clk);
    chk("rst_sdo", {60'd0, sdo}, 64'd0);
    chk("rst_ready", {63'd0, data_ready}, 64'd0);
    chk("rst_clk_en", {63'd0, clk_en_o}, 64'd0);
    chk("rst_tx_done", {63'd0, tx_done}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    step;
    rstn = 1;
    gen_on = 1;
    step;
    words = '{32'hA5000001};
    run_xfer(2'd0, 1'b0, 32, 0, 0);
    words = '{32'h12345678, 32'h9ABCDEF0};
    run_xfer(2'd2, 1'b0, 64, 0, 0);
    words = '{32'hFFFFFFE4};
    run_xfer(2'd1, 1'b1, 8, 0, 0);
    words = '{$urandom(), $urandom()};
    run_xfer(2'd0, 1'b0, 64, 5, 0);
    words = '{$urandom()};
    run_xfer(2'd0, 1'b0, 32, 0, 1);
    words = '{$urandom()};
    push_exp(2'd0, 1'b0, 32);
    feed(0, 0);
    // abort after five beats
    start_single32;
    wait_edges(5);
    gen_on = 0;
    step;
    abort = 1;
    @(negedge clk);
    chk("abort_tx_done", {63'd0, tx_done}, 64'd0);
    chk("abort_ready", {63'd0, data_ready}, 64'd0);
    step;
    abort = 0;
    @(negedge clk);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_sdo", {60'd0, sdo}, 64'd0);
    chk("abort_clk_en", {63'd0, clk_en_o}, 64'd0);
    exp_q.delete();
    gen_on = 1;
    step;
    words = '{$urandom()};
    run_xfer(2'd2, 1'b1, 32, 0, 0);
    // zero-length target never starts
    mode = 0;
    bit_len = '0;
    bit_len_upd = 1;
    step;
    bit_len_upd = 0;
    en = 1;
    data = $urandom();
    data_valid = 1;
    repeat (4) begin
      @(negedge clk);
      chk("zero_ready", {63'd0, data_ready}, 64'd0);
      chk("zero_busy", {63'd0, busy}, 64'd0);
    end
    step;
    data_valid = 0;
    // asynchronous reset mid-transfer restores the default target of 8
    start_single32;
    wait_edges(3);
    #2 rstn = 0;
    #1;
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_sdo", {60'd0, sdo}, 64'd0);
    chk("arst_clk_en", {63'd0, clk_en_o}, 64'd0);
    exp_q.delete();
    step;
    rstn = 1;
    step;
    words = '{$urandom()};
    mode = 0;
    lsb_first = 0;
    push_exp(2'd0, 1'b0, 8);
    feed(0, 0);
    for (int r = 0; r < 20; r++) begin
      m = $urandom_range(0, 3);
      l = lines(2'(m));
      t = $urandom_range(1, 3 * DW / l);
      nw = (t + DW / l - 1) / (DW / l);
      words.delete();
      for (int i = 0; i < nw; i++) words.push_back($urandom());
      run_xfer(2'(m), 1'($urandom_range(0, 1)), t * l + $urandom_range(0, l - 1), $urandom_range(0, 3), 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_master_tx_multi.md
# spi_master_tx_multi

Parametrised SPI master transmit shifter: successor to the fixed 32-bit single/quad transmitter in the APB SPI master. Serialises DW-bit words onto 1, 2 or 4 data lines, MSB- or LSB-first, for a programmable transfer length. Instead of dropping to idle when the FIFO runs dry mid-transfer, it holds the SPI clock in a stall state. Sits between the TX FIFO (valid/ready) and the SPI clock generator (tx_edge in, clk_en_o out).

## Interface
- DW, 32: word width in bits; multiple of 4, ≥ 8.
- CNT_W, 16: width of the bit-length and beat counters.
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- en  in  1  transfer enable; sampled only at start and at end of transfer.
- abort  in  1  synchronous abort; forces IDLE next cycle.
- tx_edge  in  1  one-cycle strobe from the clock generator: shift now.
- mode  in  2  00 single, 01 dual, 10 quad, 11 treated as single.
- lsb_first  in  1  0: MSB first, 1: LSB first.
- bit_len  in  CNT_W  transfer length in bits.
- bit_len_upd  in  1  load bit_len into the target register.
- data  in  DW  TX word.
- data_valid  in  1  TX word valid.
- data_ready  out  1  word consumed this cycle (combinational).
- sdo  out  4  serial data lines.
- clk_en_o  out  1  SPI clock enable (combinational).
- tx_done  out  1  one-cycle pulse on the last beat.
- busy  out  1  high in TRANSMIT or STALL.

## Operation
- Lines per beat: L = 1/2/4 (S = log2 L). mode and lsb_first are latched into mode_r/lsb_r on the IDLE→TRANSMIT load and are held for the whole transfer.
- Target: on bit_len_upd in IDLE, target = bit_len >> S, using the mode input that cycle. The low S bits are ignored. bit_len_upd outside IDLE is ignored. Reset value is 8.
- target == 0: IDLE never starts, and data_ready stays 0.
- States:
  - IDLE: if en && data_valid && target != 0, load shreg = data, data_ready = 1, beat = 0, wbeat = 0, go to TRANSMIT.
  - TRANSMIT: clk_en_o = 1. On tx_edge, shift shreg by L (left if MSB-first, right if LSB-first, zero fill), beat++, wbeat++.
    - Last beat (beat == target−1): tx_done = 1, beat = 0, wbeat = 0.
      - If en && data_valid: reload, data_ready = 1, stay in TRANSMIT.
      - Otherwise: clk_en_o = 0, go to IDLE.
    - Word boundary (wbeat == DW/L−1, not the last beat): wbeat = 0.
      - If data_valid: reload, data_ready = 1.
      - Otherwise: clk_en_o = 0, go to STALL.
  - STALL: clk_en_o = 0, counters held. When data_valid: reload, data_ready = 1, clk_en_o = 1, go to TRANSMIT.
- Last beat takes priority over word boundary when both hit on the same tx_edge.
- sdo mapping (unused lines drive 0):
  - MSB-first: single sdo[0] = shreg[DW−1]; dual sdo[1:0] = shreg[DW−1:DW−2]; quad sdo[3:0] = shreg[DW−1:DW−4].
  - LSB-first: sdo[L−1:0] = shreg[L−1:0].
- abort: from any state, next cycle go to IDLE with beat = 0, wbeat = 0, shreg = 0. No tx_done, and data_ready = 0 that cycle. abort has priority over all other events.
- en low mid-transfer: the current transfer completes, and en is then checked at the last beat.
- Counters are CNT_W bits. beat never wraps, because it resets at target−1.

## Timing
- Reset values: shreg 0, state IDLE, beat 0, wbeat 0, target 8, mode_r 0, lsb_r 0.
- Outputs after reset: sdo 0, data_ready 0, clk_en_o 0, tx_done 0, busy 0.
- Start: the word is loaded on the clock edge after the data_valid && data_ready cycle, and its first bits appear on sdo that cycle.
- Each tx_edge updates sdo one clock later.
- data_ready and tx_done are combinational, in the same cycle as tx_edge (or as data_valid in IDLE and STALL).
- Back-to-back words and transfers add zero gap beats when data_valid is high at the boundary.
- Reset asserted mid-operation: all registers return to their reset values immediately (asynchronously).

## Test plan
- Single-line, MSB-first, DW=32, bit_len 32, data 0xA5000001:
  - sdo[0] sequence is 1,0,1,0,0,1,0,1,0…0,1.
  - tx_done pulses once on the 32nd tx_edge, then IDLE and clk_en_o = 0.
- Quad, bit_len 64, two words 0x12345678 and 0x9ABCDEF0 queued:
  - sdo[3:0] nibbles are 1,2,…,8,9,A,…,0 with no gap.
  - data_ready pulses on the start cycle and on tx_edge 8.
  - tx_done pulses on tx_edge 16.
- Dual, LSB-first, bit_len 8, data 0x…E4:
  - sdo[1:0] = 0,1,2,3.
  - sdo[3:2] stays 0.
- Stall: single mode, bit_len 64, second word withheld for 5 cycles:
  - clk_en_o = 0 and busy = 1 for those 5 cycles.
  - The word is then accepted and the remaining 32 bits are correct.
- Abort after 5 tx_edges:
  - IDLE next cycle, sdo = 0, no tx_done.
  - The next transfer starts cleanly from beat 0.
- bit_len_upd = 1 with bit_len 0, then data_valid:
  - no data_ready and the block stays in IDLE.
- bit_len_upd while busy:
  - the target is unchanged.
